// File: rtl/bounce_generator.sv
// Button-bounce emulator: turns a clean level into repeatable LFSR-timed chatter followed by a settled level.
// Optional build macro BOUNCE_GEN_RANDOM_COUNT_EN draws the glitch count per edge from the LFSR.
module bounce_generator #(
    parameter int          MAX_BOUNCES   = 4,
    parameter int          GLITCH_W      = 3,
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic bouncy_o,
    output logic busy_o,
    output logic done_o
);
    localparam int PW = $clog2(MAX_BOUNCES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = GLITCH_W + 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            stable_q, stable_d;
    logic            target_q, target_d;
    logic            phase_q, phase_d;
    logic [PW-1:0]   pairs_q, pairs_d;
    logic [CW-1:0]   seg_cnt_q, seg_cnt_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            bouncy_q, bouncy_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [CW-1:0]   seg_len;
    logic [PW-1:0]   n_sel;

    assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign seg_len = {1'b0, lfsr_q[GLITCH_W-1:0]} + CW'(1);

`ifdef BOUNCE_GEN_RANDOM_COUNT_EN
    logic [PW-1:0] n_rand;
    assign n_rand = lfsr_q[8 +: PW];
    // Out-of-range draws (zero or above the cap) fall back to the full count.
    assign n_sel  = (n_rand != '0 && int'(n_rand) <= MAX_BOUNCES) ? n_rand : PW'(MAX_BOUNCES);
`else
    assign n_sel  = PW'(MAX_BOUNCES);
`endif

    always_comb begin
        state_d      = state_q;
        stable_d     = stable_q;
        target_d     = target_q;
        phase_d      = phase_q;
        pairs_d      = pairs_q;
        seg_cnt_d    = seg_cnt_q;
        settle_cnt_d = settle_cnt_q;
        bouncy_d     = bouncy_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                bouncy_d = stable_q;
                busy_d   = 1'b0;
                if (level_i != stable_q) begin
                    target_d  = level_i;
                    pairs_d   = n_sel;
                    seg_cnt_d = seg_len;
                    phase_d   = 1'b0;
                    bouncy_d  = level_i;
                    busy_d    = 1'b1;
                    state_d   = S_BOUNCE;
                end
            end
            S_BOUNCE: begin
                if (seg_cnt_q == CW'(1)) begin
                    if (!phase_q) begin
                        phase_d   = 1'b1;
                        bouncy_d  = ~target_q;
                        seg_cnt_d = seg_len;
                    end else if (pairs_q > PW'(1)) begin
                        pairs_d   = pairs_q - PW'(1);
                        phase_d   = 1'b0;
                        bouncy_d  = target_q;
                        seg_cnt_d = seg_len;
                    end else begin
                        bouncy_d     = target_q;
                        settle_cnt_d = SW'(SETTLE_CYCLES);
                        state_d      = S_SETTLE;
                    end
                end else begin
                    seg_cnt_d = seg_cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                bouncy_d = target_q;
                if (settle_cnt_q == SW'(1)) begin
                    stable_d = target_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                bouncy_d = stable_q;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            stable_q     <= 1'b0;
            target_q     <= 1'b0;
            phase_q      <= 1'b0;
            pairs_q      <= '0;
            seg_cnt_q    <= '0;
            settle_cnt_q <= '0;
            lfsr_q       <= SEED_EFF;
            bouncy_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_q     <= stable_d;
            target_q     <= target_d;
            phase_q      <= phase_d;
            pairs_q      <= pairs_d;
            seg_cnt_q    <= seg_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            lfsr_q       <= lfsr_d;
            bouncy_q     <= bouncy_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bouncy_o = bouncy_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
endmodule
